core_task_loader: RTL

Per-core receive end of the scheduler-to-core task broadcast. Accepts the header and instruction beats that `new_sched` drives on the shared core bus, filters them by core mask, and writes the instructions into the core's local instruction memory. It then hands the task to the core's execute unit and drives this core's bit of `core_ready` / `core_reading` back to the scheduler. One instance per core; `CORE_ID` selects the mask bit.

---
 rtl/core_task_loader.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/core_task_loader.sv
// core_task_loader: per-core receiver for the scheduler task broadcast.
// Accepts a header beat (word count N, optional checksum) followed by ceil(N/2)
// payload beats, writes them into the local instruction memory as word pairs,
// then pulses exec_start and waits for exec_done before going idle again.
// Optional feature: define CORE_TASK_LOADER_CKSUM_EN to check the header XOR checksum.
module core_task_loader #(
    parameter int unsigned CORE_ID     = 0,
    parameter int unsigned CORE_NUM    = 16,
    parameter int unsigned INSTR_SIZE  = 16,
    parameter int unsigned BUS_TO_CORE = 2 * INSTR_SIZE,
    parameter int unsigned MEM_DEPTH   = 64,
    localparam int unsigned AW         = $clog2(MEM_DEPTH) - 1,
    localparam int unsigned LW         = $clog2(MEM_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_being_sent,
    input  logic [CORE_NUM-1:0]    core_mask,
    input  logic [BUS_TO_CORE-1:0] bus_data,
    output logic                   core_reading,
    output logic                   core_ready,
    output logic [1:0]             imem_we,
    output logic [AW-1:0]          imem_addr,
    output logic [BUS_TO_CORE-1:0] imem_wdata,
    output logic [LW-1:0]          task_len,
    output logic                   exec_start,
    input  logic                   exec_done,
    output logic                   cksum_err
);

    typedef enum logic [1:0] {StIdle, StLoad, StStart, StRun} state_e;

    // Pairs that fit in memory; beats at or beyond this are consumed but not written.
    localparam logic [INSTR_SIZE-2:0] PairLimit = (INSTR_SIZE - 1)'(MEM_DEPTH / 2);

    state_e                 state_q, state_d;
    logic [INSTR_SIZE-1:0]  n_q, n_d;          // full header word count, unsaturated
    logic [INSTR_SIZE-2:0]  pair_q, pair_d;    // wide enough to never wrap for any N
    logic [LW-1:0]          task_len_q, task_len_d;
    logic [1:0]             we_q, we_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [BUS_TO_CORE-1:0] wdata_q, wdata_d;
    logic                   start_q, start_d;
    logic                   err_q, err_d;
    logic                   ready_q, ready_d;
    logic                   reading_q, reading_d;
    logic                   done_pend_q, done_pend_d;  // exec_done seen while in START
`ifdef CORE_TASK_LOADER_CKSUM_EN
    logic [INSTR_SIZE-1:0]  cksum_q, cksum_d;
    logic [INSTR_SIZE-1:0]  acc_q, acc_d;
`endif

    logic                  accept;
    logic                  last_beat;
    logic                  lo_fits;
    logic                  hi_in_task;
    logic [INSTR_SIZE-1:0] hdr_n;
    logic [INSTR_SIZE-1:0] lo_word;
    logic [INSTR_SIZE-1:0] hi_word;
    logic                  unused_ok;

    assign accept     = frame_being_sent & core_mask[CORE_ID] & reading_q;
    assign hdr_n      = bus_data[INSTR_SIZE-1:0];
    assign lo_word    = bus_data[INSTR_SIZE-1:0];
    assign hi_word    = bus_data[2*INSTR_SIZE-1:INSTR_SIZE];
    assign lo_fits    = pair_q < PairLimit;
    assign hi_in_task = {pair_q, 1'b1} < n_q;
    // Last beat once the words covered so far (2*pair+2) reach N.
    assign last_beat  = ({1'b0, pair_q, 1'b0} + (INSTR_SIZE + 1)'(2)) >= {1'b0, n_q};
    assign unused_ok  = ^{core_mask, bus_data};

    // Next-state and next-output computation for the load/start/run sequence.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        pair_d      = pair_q;
        task_len_d  = task_len_q;
        we_d        = 2'b00;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        start_d     = 1'b0;
        err_d       = 1'b0;
        done_pend_d = 1'b0;
`ifdef CORE_TASK_LOADER_CKSUM_EN
        cksum_d     = cksum_q;
        acc_d       = acc_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept && hdr_n != '0) begin
                    n_d    = hdr_n;
                    pair_d = '0;
                    if (hdr_n > INSTR_SIZE'(MEM_DEPTH)) begin
                        task_len_d = LW'(MEM_DEPTH);
                    end else begin
                        task_len_d = LW'(hdr_n);
                    end
`ifdef CORE_TASK_LOADER_CKSUM_EN
                    cksum_d = hi_word;
                    acc_d   = '0;
`endif
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (accept) begin
                    we_d    = {lo_fits & hi_in_task, lo_fits};
                    addr_d  = pair_q[AW-1:0];
                    wdata_d = bus_data;
                    pair_d  = pair_q + 1'b1;
`ifdef CORE_TASK_LOADER_CKSUM_EN
                    // Checksum covers every word of the task, written or not.
                    acc_d = acc_q ^ lo_word ^ (hi_in_task ? hi_word : '0);
`endif
                    if (last_beat) begin
                        state_d = StStart;
                    end
                end
            end
            StStart: begin
`ifdef CORE_TASK_LOADER_CKSUM_EN
                if (acc_q != cksum_q) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    start_d     = 1'b1;
                    done_pend_d = exec_done;
                    state_d     = StRun;
                end
`else
                start_d     = 1'b1;
                done_pend_d = exec_done;
                state_d     = StRun;
`endif
            end
            StRun: begin
                if (exec_done || done_pend_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        ready_d   = (state_d == StIdle);
        reading_d = (state_d == StIdle) || (state_d == StLoad);
    end

    // State and registered outputs; reset returns to idle immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            n_q         <= '0;
            pair_q      <= '0;
            task_len_q  <= '0;
            we_q        <= 2'b00;
            addr_q      <= '0;
            wdata_q     <= '0;
            start_q     <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b1;
            reading_q   <= 1'b1;
            done_pend_q <= 1'b0;
`ifdef CORE_TASK_LOADER_CKSUM_EN
            cksum_q     <= '0;
            acc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            pair_q      <= pair_d;
            task_len_q  <= task_len_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            start_q     <= start_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
            reading_q   <= reading_d;
            done_pend_q <= done_pend_d;
`ifdef CORE_TASK_LOADER_CKSUM_EN
            cksum_q     <= cksum_d;
            acc_q       <= acc_d;
`endif
        end
    end

    assign core_reading = reading_q;
    assign core_ready   = ready_q;
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign task_len     = task_len_q;
    assign exec_start   = start_q;
    assign cksum_err    = err_q;

endmodule
